writeback_buffer: RTL and testbench

WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

---
 rtl/riscv_pkg.sv | 19 +
 rtl/wb_fwd_match.sv | 34 +++
 rtl/writeback_buffer.sv | 142 ++++++++++++++
 tb/tb_writeback_buffer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: register-file geometry and the writeback entry type.
package riscv_pkg;

  // Architectural register address width (x0..x31).
  localparam int REG_ADDR_W = 5;

  // Default number of pending writes held between the pipes and the regfile.
  localparam int WB_DEPTH = 4;

  // Native register value width; the writeback buffer data width matches it.
  localparam int XLEN = 32;

  // One pending register write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the valid window of the writeback FIFO.
// Entries are visited oldest to youngest starting at the head; a later match
// overrides an earlier one, so the surviving result is the youngest write.
module wb_fwd_match
  import riscv_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int V     = XLEN
) (
  input  wb_entry_t [DEPTH-1:0]       entries,
  input  logic [$clog2(DEPTH)-1:0]    head,
  input  logic [$clog2(DEPTH):0]      count,
  input  logic [REG_ADDR_W-1:0]       rs,
  output logic                        hit,
  output logic [V-1:0]                data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Walk the occupied slots in age order; x0 never matches.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (rs != '0) &&
          (entries[head + PTR_W'(i)].rd == rs)) begin
        hit  = 1'b1;
        data = V'(entries[head + PTR_W'(i)].data);
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer: merges integer-pipe and FPU results into a small circular
// FIFO that drains one entry per cycle into the register file, and offers
// youngest-match forwarding of pending writes on two read addresses.
//
// Handshake: a producer request is taken on a rising edge where its valid and
// ready are both high. Ready is computed from registered occupancy only (plus
// fpu_valid for the integer side, since the FPU wins the last free slot) and
// never depends on the same-cycle drain. A taken request to x0 completes the
// handshake but is dropped instead of being stored.
module writeback_buffer
  import riscv_pkg::*;
#(
  parameter int V     = 32,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // integer-pipe write request
  input  logic                        int_valid,
  output logic                        int_ready,
  input  logic [4:0]                  int_rd,
  input  logic [V-1:0]                int_data,
  // FPU write request
  input  logic                        fpu_valid,
  output logic                        fpu_ready,
  input  logic [4:0]                  fpu_rd,
  input  logic [V-1:0]                fpu_data,
  // register-file write port
  output logic                        Reg_write,
  output logic [4:0]                  wr_adder,
  output logic [V-1:0]                wr_data,
  // forwarding lookup
  input  logic [4:0]                  rs1,
  input  logic [4:0]                  rs2,
  output logic                        fwd1_hit,
  output logic [V-1:0]                fwd1_data,
  output logic                        fwd2_hit,
  output logic [V-1:0]                fwd2_data,
  // occupancy
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  wb_entry_t [DEPTH-1:0] entries_q, entries_d;

  logic [CNT_W-1:0]      free;
  logic                  fpu_acc, int_acc;
  logic                  fpu_push, int_push;
  logic                  pop;
  logic [1:0]            n_push;
  logic [PTR_W-1:0]      int_slot;

  // Producer readiness from registered occupancy; the FPU has first claim.
  always_comb begin
    free      = CNT_W'(DEPTH) - count_q;
    fpu_ready = (free >= CNT_W'(1));
    int_ready = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !fpu_valid);
  end

  // Accept/push/pop decisions for this cycle.
  always_comb begin
    fpu_acc  = fpu_valid && fpu_ready;
    int_acc  = int_valid && int_ready;
    fpu_push = fpu_acc && (fpu_rd != '0);
    int_push = int_acc && (int_rd != '0);
    pop      = (count_q != '0);
    n_push   = {1'b0, fpu_push} + {1'b0, int_push};
  end

  // Next-state for storage and pointers: FPU lands at the tail (older), the
  // integer entry right behind it when both push together.
  always_comb begin
    entries_d = entries_q;
    int_slot  = fpu_push ? (tail_q + PTR_W'(1)) : tail_q;
    if (fpu_push) begin
      entries_d[tail_q].rd   = fpu_rd;
      entries_d[tail_q].data = XLEN'(fpu_data);
    end
    if (int_push) begin
      entries_d[int_slot].rd   = int_rd;
      entries_d[int_slot].data = XLEN'(int_data);
    end
    tail_d  = tail_q + PTR_W'(n_push);
    head_d  = head_q + PTR_W'(pop);
    count_d = count_q + CNT_W'(n_push) - CNT_W'(pop);
  end

  // Control state: pointers and occupancy, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage; validity comes solely from head/count.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  // Register-file write port driven straight from the head entry.
  assign Reg_write = pop;
  assign wr_adder  = entries_q[head_q].rd;
  assign wr_data   = V'(entries_q[head_q].data);
  assign count     = count_q;

  // Forwarding: one youngest-match searcher per read address.
  wb_fwd_match #(
    .DEPTH (DEPTH),
    .V     (V)
  ) u_fwd1 (
    .entries (entries_q),
    .head    (head_q),
    .count   (count_q),
    .rs      (rs1),
    .hit     (fwd1_hit),
    .data    (fwd1_data)
  );

  wb_fwd_match #(
    .DEPTH (DEPTH),
    .V     (V)
  ) u_fwd2 (
    .entries (entries_q),
    .head    (head_q),
    .count   (count_q),
    .rs      (rs2),
    .hit     (fwd2_hit),
    .data    (fwd2_data)
  );

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: reset, single/dual writes, fill with
// readiness model, forwarding, x0 drop and reset during operation.
module tb_writeback_buffer;

  localparam int V     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         int_valid, fpu_valid;
  logic         int_ready, fpu_ready;
  logic [4:0]   int_rd, fpu_rd;
  logic [V-1:0] int_data, fpu_data;
  logic         Reg_write;
  logic [4:0]   wr_adder;
  logic [V-1:0] wr_data;
  logic [4:0]   rs1, rs2;
  logic         fwd1_hit, fwd2_hit;
  logic [V-1:0] fwd1_data, fwd2_data;
  logic [2:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected register-file writes, {rd, data}, oldest first.
  logic [36:0] exp_q[$];

  writeback_buffer #(.V(V), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .int_valid (int_valid),
    .int_ready (int_ready),
    .int_rd    (int_rd),
    .int_data  (int_data),
    .fpu_valid (fpu_valid),
    .fpu_ready (fpu_ready),
    .fpu_rd    (fpu_rd),
    .fpu_data  (fpu_data),
    .Reg_write (Reg_write),
    .wr_adder  (wr_adder),
    .wr_data   (wr_data),
    .rs1       (rs1),
    .rs2       (rs2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .count     (count)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    int_valid = 1'b0;
    int_rd    = '0;
    int_data  = '0;
    fpu_valid = 1'b0;
    fpu_rd    = '0;
    fpu_data  = '0;
  endtask

  task automatic drive_int(input logic [4:0] rd, input logic [31:0] data);
    int_valid = 1'b1;
    int_rd    = rd;
    int_data  = data;
  endtask

  task automatic drive_fpu(input logic [4:0] rd, input logic [31:0] data);
    fpu_valid = 1'b1;
    fpu_rd    = rd;
    fpu_data  = data;
  endtask

  task automatic check_port(input string tag);
    if (exp_q.size() > 0) begin
      check({tag, "_wr"},    32'(Reg_write), 32'd1);
      check({tag, "_adder"}, 32'(wr_adder),  32'(exp_q[0][36:32]));
      check({tag, "_data"},  wr_data,        exp_q[0][31:0]);
    end else begin
      check({tag, "_wr"}, 32'(Reg_write), 32'd0);
    end
  endtask

  initial begin
    int  free;
    logic exp_fr, exp_ir, saw_block;

    idle();
    rs1   = '0;
    rs2   = '0;
    rst_n = 1'b0;

    // Reset state.
    repeat (3) next_cycle();
    check("rst_wr",    32'(Reg_write), 32'd0);
    check("rst_count", 32'(count),     32'd0);
    check("rst_fwd1",  32'(fwd1_hit),  32'd0);
    check("rst_fwd2",  32'(fwd2_hit),  32'd0);
    check("rst_irdy",  32'(int_ready), 32'd1);
    check("rst_frdy",  32'(fpu_ready), 32'd1);
    rst_n = 1'b1;
    next_cycle();
    check("post_rst_wr",    32'(Reg_write), 32'd0);
    check("post_rst_count", 32'(count),     32'd0);

    // Single integer write, with the incoming request excluded from forwarding.
    drive_int(5'd5, 32'hDEADBEEF);
    rs1 = 5'd5;
    #1;
    check("single_irdy",      32'(int_ready), 32'd1);
    check("fwd_excl_incoming", 32'(fwd1_hit), 32'd0);
    next_cycle();
    idle();
    rs1 = '0;
    check("single_wr",    32'(Reg_write), 32'd1);
    check("single_adder", 32'(wr_adder),  32'd5);
    check("single_data",  wr_data,        32'hDEADBEEF);
    check("single_count", 32'(count),     32'd1);
    next_cycle();
    check("single_done_wr",    32'(Reg_write), 32'd0);
    check("single_done_count", 32'(count),     32'd0);

    // Dual accept: FPU entry written first.
    drive_fpu(5'd3, 32'h1);
    drive_int(5'd4, 32'h2);
    #1;
    check("dual_irdy", 32'(int_ready), 32'd1);
    check("dual_frdy", 32'(fpu_ready), 32'd1);
    next_cycle();
    idle();
    check("dual_count0", 32'(count),     32'd2);
    check("dual_wr0",    32'(Reg_write), 32'd1);
    check("dual_adder0", 32'(wr_adder),  32'd3);
    check("dual_data0",  wr_data,        32'h1);
    next_cycle();
    check("dual_count1", 32'(count),     32'd1);
    check("dual_adder1", 32'(wr_adder),  32'd4);
    check("dual_data1",  wr_data,        32'h2);
    next_cycle();
    check("dual_done_wr", 32'(Reg_write), 32'd0);

    // Forwarding: two pending writes to x7, youngest wins; rs2 = x0 never hits.
    drive_fpu(5'd7, 32'hA);
    drive_int(5'd7, 32'hB);
    rs1 = 5'd7;
    rs2 = 5'd0;
    next_cycle();
    idle();
    check("fwd_count",   32'(count),     32'd2);
    check("fwd1_hit",    32'(fwd1_hit),  32'd1);
    check("fwd1_young",  fwd1_data,      32'hB);
    check("fwd2_x0_hit", 32'(fwd2_hit),  32'd0);
    check("fwd2_x0_dat", fwd2_data,      32'h0);
    rs2 = 5'd7;
    #1;
    check("fwd2_hit",   32'(fwd2_hit), 32'd1);
    check("fwd2_young", fwd2_data,     32'hB);
    next_cycle();
    check("fwd1_head_hit",  32'(fwd1_hit), 32'd1);
    check("fwd1_head_data", fwd1_data,     32'hB);
    next_cycle();
    check("fwd1_empty_hit",  32'(fwd1_hit), 32'd0);
    check("fwd1_empty_data", fwd1_data,     32'h0);

    // Distinct addresses: head entry and tail entry both searchable.
    drive_fpu(5'd9,  32'h11);
    drive_int(5'd10, 32'h22);
    rs1 = 5'd9;
    rs2 = 5'd10;
    next_cycle();
    idle();
    check("fwd_old_hit",  32'(fwd1_hit), 32'd1);
    check("fwd_old_data", fwd1_data,     32'h11);
    check("fwd_new_hit",  32'(fwd2_hit), 32'd1);
    check("fwd_new_data", fwd2_data,     32'h22);
    next_cycle();
    check("fwd_old_gone", 32'(fwd1_hit), 32'd0);
    check("fwd_new_stay", fwd2_data,     32'h22);
    next_cycle();
    rs1 = '0;
    rs2 = '0;

    // x0 write: handshake completes, nothing stored.
    drive_int(5'd0, 32'hFFFF);
    #1;
    check("x0_irdy", 32'(int_ready), 32'd1);
    next_cycle();
    idle();
    check("x0_count", 32'(count),     32'd0);
    check("x0_wr",    32'(Reg_write), 32'd0);
    next_cycle();
    check("x0_wr_later", 32'(Reg_write), 32'd0);

    // Fill: both producers held valid; readiness follows occupancy.
    saw_block = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_fpu(5'(8 + i),  32'h100 + 32'(i));
      drive_int(5'(16 + i), 32'h200 + 32'(i));
      #1;
      free   = DEPTH - exp_q.size();
      exp_fr = (free >= 1);
      exp_ir = (free >= 2) || ((free == 1) && !fpu_valid);
      check("fill_count", 32'(count),     32'(exp_q.size()));
      check("fill_le_depth", 32'(count <= 3'(DEPTH)), 32'd1);
      check("fill_frdy",  32'(fpu_ready), 32'(exp_fr));
      check("fill_irdy",  32'(int_ready), 32'(exp_ir));
      if (free == 1 && !int_ready) saw_block = 1'b1;
      check_port("fill");
      next_cycle();
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_fr) exp_q.push_back({fpu_rd, fpu_data});
      if (exp_ir) exp_q.push_back({int_rd, int_data});
    end
    check("fill_int_blocked", 32'(saw_block), 32'd1);

    // Drain remaining entries in order, bounded.
    idle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      check_port("drain");
      next_cycle();
      void'(exp_q.pop_front());
    end
    check("drain_left",  32'(exp_q.size()), 32'd0);
    check("drain_wr",    32'(Reg_write),    32'd0);
    check("drain_count", 32'(count),        32'd0);

    // Reset mid-operation with three entries pending.
    drive_fpu(5'd1, 32'h1);
    drive_int(5'd2, 32'h2);
    next_cycle();
    drive_fpu(5'd3, 32'h3);
    drive_int(5'd4, 32'h4);
    next_cycle();
    idle();
    rs1 = 5'd4;
    #1;
    check("midrst_count_pre", 32'(count),    32'd3);
    check("midrst_fwd_pre",   32'(fwd1_hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_wr",    32'(Reg_write), 32'd0);
    check("midrst_count", 32'(count),     32'd0);
    check("midrst_fwd",   32'(fwd1_hit),  32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      check("after_rst_wr",    32'(Reg_write), 32'd0);
      check("after_rst_count", 32'(count),     32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
